// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants used by fetch and decode, fetch
// state encoding and instruction size.
package core_pkg;

  localparam logic [6:0] R_ALU  = 7'b0110011;
  localparam logic [6:0] I_ALU  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter: synchronous reset, word-aligned load and wrapping increment.
module pc_reg
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);

  // Load beats increment; the adder wraps naturally modulo 2^XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val & ALIGN_MASK;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, issues one word read at a time,
// holds the fetched word for decode and halts on an illegal opcode.
module inst_fetch
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  input  logic            is_an_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted,
  output logic [XLEN-1:0] illegal_pc
);

  // Handshakes: a transfer happens in a cycle where valid && ready; a valid
  // source keeps its payload stable until that cycle (a redirect may retarget).

  logic [1:0]      state;
  logic            drop;
  logic [XLEN-1:0] pc;
  logic            pc_load;
  logic            pc_inc;
  logic            req_fire;

  assign imem_req_valid = (state == ST_FETCH) && !rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign opcode         = inst[6:0];

  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state)
      ST_FETCH, ST_WAIT: pc_load = redirect_valid;
      ST_HOLD: begin
        pc_load = redirect_valid;
        pc_inc  = !redirect_valid && inst_valid && inst_ready && is_an_inst;
      end
      default: ;
    endcase
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      halted     <= 1'b0;
      illegal_pc <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          // A redirect coinciding with acceptance makes the response stale.
          if (req_fire) begin
            state <= ST_WAIT;
            drop  <= redirect_valid;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            drop <= 1'b0;
            if (redirect_valid || drop) begin
              state <= ST_FETCH;
            end else begin
              inst       <= imem_rsp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            state      <= ST_FETCH;
          end else if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            if (is_an_inst) begin
              state <= ST_FETCH;
            end else begin
              halted     <= 1'b1;
              illegal_pc <= inst_pc;
              state      <= ST_HALT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small request/response memory model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        is_an_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] illegal_pc;

  logic        d2_req_valid;
  logic [31:0] d2_req_addr;
  logic        d2_inst_valid;
  logic [31:0] d2_inst;
  logic [31:0] d2_inst_pc;
  logic [6:0]  d2_opcode;
  logic        d2_halted;
  logic [31:0] d2_illegal_pc;

  int          n_checks;
  int          n_fail;

  int          rsp_delay;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic        rsp_pending;
  int          rsp_cnt;
  logic [31:0] rsp_word;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .is_an_inst(is_an_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .illegal_pc(illegal_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(d2_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(d2_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(d2_inst_valid), .inst_ready(inst_ready),
    .inst(d2_inst), .inst_pc(d2_inst_pc), .opcode(d2_opcode),
    .is_an_inst(is_an_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(d2_halted), .illegal_pc(d2_illegal_pc)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[24:0], 7'b0110011};
  endfunction

  // Memory model: one response per accepted request of the primary DUT,
  // rsp_delay cycles after the cycle following acceptance.
  always @(posedge clk) begin
    logic fire;
    fire = !rst && imem_req_valid && imem_req_ready;
    #2;
    imem_rsp_valid = 1'b0;
    if (rst) rsp_pending = 1'b0;
    if (fire) begin
      rsp_pending = 1'b1;
      rsp_cnt     = rsp_delay;
      rsp_word    = ovr_en ? ovr_data : mem_word(dut.imem_req_addr);
    end
    if (rsp_pending) begin
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rsp_word;
        rsp_pending    = 1'b0;
      end else begin
        rsp_cnt = rsp_cnt - 1;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    is_an_inst     = 1'b1;
    imem_req_ready = 1'b1;
    rsp_delay      = 0;
    ovr_en         = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    inst_ready     = 1'b1;
    is_an_inst     = 1'b1;
    imem_req_ready = 1'b1;
    rsp_delay      = 0;
    ovr_en         = 1'b0;
    repeat (2) tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 00000000", imem_req_addr); end
    n_checks++; if (d2_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_addr_d2 got %h exp fffffffc", d2_req_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0 || opcode !== 7'h0) begin n_fail++; $display("FAIL reset_inst got %h/%h/%h exp 0/0/0", inst, inst_pc, opcode); end
    n_checks++; if (halted !== 1'b0 || illegal_pc !== 32'h0) begin n_fail++; $display("FAIL reset_halt got %b/%h exp 0/0", halted, illegal_pc); end
    redirect_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_req got %b exp 1", imem_req_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_req[%0d] got %b/%h exp 1/%h", i, imem_req_valid, imem_req_addr, 32'(4 * i)); end
      tick();
      n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_wait[%0d] got req %b inst_valid %b exp 0/0", i, imem_req_valid, inst_valid); end
      tick();
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== mem_word(32'(4 * i))) begin n_fail++; $display("FAIL stream_inst[%0d] got %b/%h/%h exp 1/%h/%h", i, inst_valid, inst_pc, inst, 32'(4 * i), mem_word(32'(4 * i))); end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    ovr_en     = 1'b1;
    ovr_data   = 32'h0000_006F;
    inst_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_006F || inst_pc !== 32'h0 || opcode !== 7'b1101111) begin n_fail++; $display("FAIL hold_stable[%0d] got %b/%h/%h/%b exp 1/0000006f/0/1101111", i, inst_valid, inst, inst_pc, opcode); end
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_req[%0d] got %b exp 0", i, imem_req_valid); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL hold_consume got %b/%b/%h exp 0/1/00000004", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rsp_delay = 2;
    ovr_en    = 1'b1;
    ovr_data  = 32'hDEAD_BEEF;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 0;
    ovr_en         = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rwait_still_wait got %b/%b exp 0/0", imem_req_valid, inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rwait_rsp_cycle got %b/%b exp 0/0", inst_valid, imem_req_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rwait_refetch got %b/%b/%h exp 0/1/00000100", inst_valid, imem_req_valid, imem_req_addr); end
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL rwait_new_inst got %b/%h/%h exp 1/00000100/%h", inst_valid, inst_pc, inst, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL racc_wait got %b/%h exp 0/00000200", imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL racc_refetch got %b/%b/%h exp 0/1/00000200", inst_valid, imem_req_valid, imem_req_addr); end
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin n_fail++; $display("FAIL racc_inst got %b/%h exp 1/00000200", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0046;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h44) begin n_fail++; $display("FAIL rfetch_addr got %b/%h exp 1/00000044", imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h44) begin n_fail++; $display("FAIL rfetch_stable got %b/%h exp 1/00000044", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_redirect_hold();
    do_reset();
    inst_ready = 1'b0;
    tick();
    tick();
    inst_ready     = 1'b1;
    is_an_inst     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    is_an_inst     = 1'b1;
    n_checks++; if (halted !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_no_halt got %b/%b exp 0/0", halted, inst_valid); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rhold_addr got %b/%h exp 1/00000300", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (6) tick();
    n_checks++; if (imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL halt_pre_addr got %h exp 00000008", imem_req_addr); end
    tick();
    is_an_inst = 1'b0;
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin n_fail++; $display("FAIL halt_pre_inst got %b/%h exp 1/00000008", inst_valid, inst_pc); end
    tick();
    n_checks++; if (halted !== 1'b1 || illegal_pc !== 32'h8 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_state got %b/%h/%b exp 1/00000008/0", halted, illegal_pc, inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    is_an_inst     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req_valid !== 1'b0 || halted !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_idle[%0d] got %b/%b/%b exp 0/1/0", i, imem_req_valid, halted, inst_valid); end
      tick();
    end
    redirect_valid = 1'b0;
    do_reset();
    n_checks++; if (halted !== 1'b0 || illegal_pc !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL halt_reset got %b/%h/%b/%h exp 0/0/1/0", halted, illegal_pc, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    n_checks++; if (d2_req_valid !== 1'b1 || d2_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first got %b/%h exp 1/fffffffc", d2_req_valid, d2_req_addr); end
    tick();
    tick();
    n_checks++; if (d2_inst_valid !== 1'b1 || d2_inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_inst got %b/%h exp 1/fffffffc", d2_inst_valid, d2_inst_pc); end
    tick();
    n_checks++; if (d2_req_valid !== 1'b1 || d2_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %b/%h exp 1/00000000", d2_req_valid, d2_req_addr); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rsp_pending    = 1'b0;
    rsp_cnt        = 0;
    rsp_word       = 32'h0;
    ovr_data       = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    test_reset();
    test_stream();
    test_hold();
    test_redirect_wait();
    test_redirect_accept();
    test_redirect_fetch();
    test_redirect_hold();
    test_halt();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
